gr8ram_dram_ctl: RTL and testbench
==================================

# gr8ram_dram_ctl

Parametrised Apple II slot controller for the GR8RAM slinky RAM card, replacing the fixed 23-bit, two-bank controller. It synchronises to the 6502 bus phase and decodes the slot's $C0n0–$C0nF register window. It sequences multiplexed DRAM RAS/CAS for data-port accesses and CAS-before-RAS refresh, all from a single rising-edge C7M clock. It sits between the Apple II slot pins and the DRAM array. It also adds configurable address step direction and an arbitrary bank count.

## Interface
- ADDR_W, 23: byte address register width, 17..24.
- BANK_BITS, 1: address MSBs selecting one of 2^BANK_BITS CAS lines.
- ROW_W, 11: DRAM mux address width; requires ADDR_W-BANK_BITS ≤ 2*ROW_W.
- REF_PERIOD, 13: bus cycles per refresh, 2..16.
- C7M in 1: 7 MHz clock, all logic on rising edge.
- RES in 1: synchronous, active-high reset.
- PHI1 in 1: delayed, hold-safe PHI1.
- nDEVSEL, nIOSEL in 1: slot selects.
- A in 4: address bits 3:0.
- nWE in 1: 6502 R/W, low is write.
- Din in 8: Apple data bus input.
- Dout out 8: Apple data bus output.
- DOE out 1: Apple data bus drive enable.
- RD_i in 8: DRAM data input.
- RD_o out 8: DRAM data output, equal to Din.
- RD_oe out 1: DRAM data drive enable.
- RA out ROW_W: DRAM address.
- nRAS out 1: DRAM RAS.
- nCAS out 2^BANK_BITS: per-bank CAS.
- nRWE out 1: DRAM write enable.
- REGEN out 1: register window enabled.

## Operation
- **State counter S (3 bits):**
  - Reset → S0 (idle), with PHI0seen=0.
  - PHI0seen sets on any edge with PHI1=0.
  - S→1 on an edge where PHI1=1, PHI1 was 0 on the previous edge, and PHI0seen=1.
  - Otherwise S0 holds, S7 holds (long cycle), and other states increment.
- **REGEN:** set at the end of S4 when nIOSEL=0. Cleared only by RES.
- **Register window** (access = nDEVSEL=0 & REGEN):
  - $0 AddrL, $1 AddrM, $2 AddrH (ADDR_W-16 LSBs used).
  - $3 DATA port, $4 CTRL (bit0 INC_EN, reset 1; bit1 DEC, reset 0).
  - Other offsets are ignored on write and read $FF.
- **Register writes:** Din is sampled at the end of S6.
- **RAMSEL** = access & A==3, sampled at the end of S4. An access cycle runs only if it is sampled.
- **Address split:**
  - Bank = Addr[ADDR_W-1 -: BANK_BITS].
  - Column = Addr[ROW_W-1:0].
  - Row = next bits, zero-padded.
- **Access sequence** (edges entering each state):
  - Entering S5: nRAS=0, RA=row; RA shows row S0–S5.
  - Entering S6: RA=column. Read: nCAS[bank]=0.
  - Entering S7: write asserts nCAS[bank]=0 and nRWE=0.
  - Entering S1, or on RES: all deassert.
- **Data port read:** Dout=RD_i.
- **Address auto-increment:**
  - Triggered by an access-cycle flag, at the end of S2 of the next bus cycle.
  - If INC_EN: Addr ← Addr±1 (DEC selects −), modulo 2^ADDR_W. $FF…F+1 → 0; 0−1 → all ones.
  - Disabled: Addr unchanged.
  - An Addr write in that later cycle (S6) overrides the increment result.
- **Refresh:**
  - Counter advances at the end of S3, wrapping at REF_PERIOD−1.
  - In cycles where it reads 0: all nCAS=0 entering S2, nRAS=0 entering S3, all deassert entering S4.
  - Refresh never overlaps S5–S7 access.
  - In S0, refresh is suppressed.
- **Drive enables:**
  - DOE = (S∈5..7) & nWE & access.
  - RD_oe = (S∈5..7) & ~nWE & RAMSEL.

## Timing
- Reset values:
  - nRAS=1, nCAS=all 1, nRWE=1, DOE=0, RD_oe=0.
  - REGEN=0, Addr=0, CTRL=01b.
  - RA=0, Dout=$FF.
- All outputs are registered except Dout/RD_o muxes.
- Read data is valid at RD_i from the S6 edge; the 6502 samples at the end of PHI0.
- Write: column/data are set up one cycle before CAS.
- RES mid-access: strobes deassert on the next edge; the pending increment is discarded.

## Configuration
- GR8RAM_ADDR_READBACK_EN:
  - Defined: reads of $0/$1/$2 return AddrL/AddrM/AddrH, with unused AddrH bits read 1; $4 returns CTRL, upper bits 1.
  - Undefined: these offsets read $FF and the readback mux is absent.

## Structure
- Package gr8ram_pkg holds:
  - State encoding S_IDLE..S_7.
  - Register offsets REG_ADDRL..REG_CTRL.
  - CTRL bit indices.
- Sub-module gr8ram_dram_seq holds the RAS/CAS/RA/nRWE generation and refresh counter. Inputs: S, RAMSEL, nWE, bank, row, column.

## Test plan
- Reset, no PHI1 edge → S stays 0, no RAS/CAS ever, REGEN=0.
- IOSEL access, then write $12/$34/$05 to $0/$1/$2, ADDR_W=23 → Addr=$053412; DRAM access uses the expected bank/row/column on RA at S5/S6.
- Read $3 ×3 with CTRL=01 → Addr steps $053412→$053415. CTRL=11 → decrements. Addr=0 with DEC → all ones.
- Write $3 → nCAS[bank] and nRWE low only S7, RD_oe S5–S7, RD_o=Din.
- REF_PERIOD=13, no accesses → exactly one CBR refresh per 13 bus cycles, all nCAS before nRAS.
- RES asserted during S6 of an access → nRAS/nCAS high on the next edge, Addr=0, no increment.

Source files
------------

// File: rtl/gr8ram_pkg.sv
// Shared definitions for the GR8RAM slot controller: bus-phase states,
// register window offsets and CTRL bit positions.
package gr8ram_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_2    = 3'd2,
    S_3    = 3'd3,
    S_4    = 3'd4,
    S_5    = 3'd5,
    S_6    = 3'd6,
    S_7    = 3'd7
  } state_e;

  localparam logic [3:0] REG_ADDRL = 4'h0;
  localparam logic [3:0] REG_ADDRM = 4'h1;
  localparam logic [3:0] REG_ADDRH = 4'h2;
  localparam logic [3:0] REG_DATA  = 4'h3;
  localparam logic [3:0] REG_CTRL  = 4'h4;

  localparam int CTRL_INC_EN = 0;
  localparam int CTRL_DEC    = 1;

  // S5..S7 is the slice of the bus cycle reserved for data-port DRAM accesses.
  function automatic logic in_access_window(input state_e s);
    return (s == S_5) || (s == S_6) || (s == S_7);
  endfunction

endpackage

// File: rtl/gr8ram_dram_seq.sv
// DRAM strobe sequencer: RAS/CAS/RA/nRWE for data-port accesses and
// CAS-before-RAS refresh, driven by the current and next bus-phase state.
module gr8ram_dram_seq
  import gr8ram_pkg::*;
#(
  parameter int BANK_BITS  = 1,
  parameter int ROW_W      = 11,
  parameter int REF_PERIOD = 13
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  state_e                      s_i,
  input  state_e                      s_nxt_i,
  input  logic                        ramsel_i,
  input  logic                        nwe_i,
  input  logic [BANK_BITS-1:0]        bank_i,
  input  logic [ROW_W-1:0]            row_i,
  input  logic [ROW_W-1:0]            col_i,
  output logic [ROW_W-1:0]            ra_o,
  output logic                        nras_o,
  output logic [(1<<BANK_BITS)-1:0]   ncas_o,
  output logic                        nrwe_o
);

  localparam logic [3:0] REF_LAST = 4'(REF_PERIOD - 1);

  logic [3:0]                  ref_cnt_q, ref_cnt_d;
  logic                        ref_q, ref_d;
  logic                        nras_q, nras_d;
  logic [(1<<BANK_BITS)-1:0]   ncas_q, ncas_d;
  logic                        nrwe_q, nrwe_d;
  logic [ROW_W-1:0]            ra_q, ra_d;

  always_comb begin
    ref_cnt_d = ref_cnt_q;
    ref_d     = ref_q;
    nras_d    = nras_q;
    ncas_d    = ncas_q;
    nrwe_d    = nrwe_q;
    ra_d      = ((s_nxt_i == S_6) || (s_nxt_i == S_7)) ? col_i : row_i;
    if (s_i == S_3) ref_cnt_d = (ref_cnt_q == REF_LAST) ? 4'd0 : ref_cnt_q + 4'd1;
    case (s_nxt_i)
      S_1: begin
        nras_d = 1'b1;
        ncas_d = '1;
        nrwe_d = 1'b1;
        ref_d  = 1'b0;
      end
      S_2: if (ref_cnt_q == 4'd0) begin
        ncas_d = '0;
        ref_d  = 1'b1;
      end
      S_3: if (ref_q) nras_d = 1'b0;
      S_4: begin
        nras_d = 1'b1;
        ncas_d = '1;
        ref_d  = 1'b0;
      end
      S_5: if (ramsel_i) nras_d = 1'b0;
      S_6: if (ramsel_i && nwe_i) ncas_d[bank_i] = 1'b0;
      // Writes hold CAS back a cycle so column and data are set up first.
      S_7: if (ramsel_i && !nwe_i) begin
        ncas_d[bank_i] = 1'b0;
        nrwe_d         = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ref_cnt_q <= 4'd0;
      ref_q     <= 1'b0;
      nras_q    <= 1'b1;
      ncas_q    <= '1;
      nrwe_q    <= 1'b1;
      ra_q      <= '0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      ref_q     <= ref_d;
      nras_q    <= nras_d;
      ncas_q    <= ncas_d;
      nrwe_q    <= nrwe_d;
      ra_q      <= ra_d;
    end
  end

  assign ra_o   = ra_q;
  assign nras_o = nras_q;
  assign ncas_o = ncas_q;
  assign nrwe_o = nrwe_q;

endmodule

// File: rtl/gr8ram_dram_ctl.sv
// GR8RAM slot controller top: bus-phase tracking, register window, address
// stepping. Define GR8RAM_ADDR_READBACK_EN to make Addr/CTRL readable.
module gr8ram_dram_ctl
  import gr8ram_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int BANK_BITS  = 1,
  parameter int ROW_W      = 11,
  parameter int REF_PERIOD = 13
) (
  input  logic                        C7M,
  input  logic                        RES,
  input  logic                        PHI1,
  input  logic                        nDEVSEL,
  input  logic                        nIOSEL,
  input  logic [3:0]                  A,
  input  logic                        nWE,
  input  logic [7:0]                  Din,
  output logic [7:0]                  Dout,
  output logic                        DOE,
  input  logic [7:0]                  RD_i,
  output logic [7:0]                  RD_o,
  output logic                        RD_oe,
  output logic [ROW_W-1:0]            RA,
  output logic                        nRAS,
  output logic [(1<<BANK_BITS)-1:0]   nCAS,
  output logic                        nRWE,
  output logic                        REGEN,
  output state_e                      dbg_state_o
);

  localparam int ROW_BITS = ADDR_W - BANK_BITS - ROW_W;

  state_e              s_q, s_d;
  logic                phi1_q, phi0seen_q;
  logic                regen_q, ramsel_q, inc_pend_q;
  logic                doe_q, rd_oe_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [ROW_W-1:0]    row;
  logic [7:0]          rd_mux;
  logic                access, ramsel_now, ramsel_eff, phi1_rise, reg_wr;

  assign access     = ~nDEVSEL & regen_q;
  assign ramsel_now = access & (A == REG_DATA);
  // RAMSEL is latched at the end of S4; the S4->S5 edge must see the live value.
  assign ramsel_eff = (s_q == S_4) ? ramsel_now : ramsel_q;
  assign phi1_rise  = PHI1 & ~phi1_q & phi0seen_q;
  assign reg_wr     = access & ~nWE & (s_q == S_6);

  always_comb begin
    s_d = s_q;
    if (phi1_rise) s_d = S_1;
    else if ((s_q != S_IDLE) && (s_q != S_7)) s_d = state_e'(s_q + 3'd1);
  end

  always_comb begin
    addr_d = addr_q;
    ctrl_d = ctrl_q;
    if ((s_q == S_2) && inc_pend_q && ctrl_q[CTRL_INC_EN])
      addr_d = ctrl_q[CTRL_DEC] ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    if (reg_wr) begin
      case (A)
        REG_ADDRL: addr_d[7:0]         = Din;
        REG_ADDRM: addr_d[15:8]        = Din;
        REG_ADDRH: addr_d[ADDR_W-1:16] = Din[ADDR_W-17:0];
        REG_CTRL:  ctrl_d              = Din[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge C7M) begin
    if (RES) begin
      s_q        <= S_IDLE;
      phi1_q     <= 1'b1;
      phi0seen_q <= 1'b0;
      regen_q    <= 1'b0;
      ramsel_q   <= 1'b0;
      inc_pend_q <= 1'b0;
      addr_q     <= '0;
      ctrl_q     <= 2'b01;
      doe_q      <= 1'b0;
      rd_oe_q    <= 1'b0;
    end else begin
      s_q        <= s_d;
      phi1_q     <= PHI1;
      phi0seen_q <= phi0seen_q | ~PHI1;
      if (s_q == S_4) begin
        ramsel_q <= ramsel_now;
        if (!nIOSEL) regen_q <= 1'b1;
      end
      if (s_q == S_2) inc_pend_q <= 1'b0;
      else if ((s_q == S_4) && ramsel_now) inc_pend_q <= 1'b1;
      addr_q     <= addr_d;
      ctrl_q     <= ctrl_d;
      doe_q      <= in_access_window(s_d) & nWE & access;
      rd_oe_q    <= in_access_window(s_d) & ~nWE & ramsel_eff;
    end
  end

  always_comb begin
    row = '0;
    row[ROW_BITS-1:0] = addr_q[ADDR_W-BANK_BITS-1:ROW_W];
  end

  always_comb begin
    rd_mux = 8'hFF;
    case (A)
      REG_DATA:  rd_mux = RD_i;
`ifdef GR8RAM_ADDR_READBACK_EN
      REG_ADDRL: rd_mux = addr_q[7:0];
      REG_ADDRM: rd_mux = addr_q[15:8];
      REG_ADDRH: rd_mux[ADDR_W-17:0] = addr_q[ADDR_W-1:16];
      REG_CTRL:  rd_mux = {6'h3F, ctrl_q};
`endif
      default: ;
    endcase
  end

  gr8ram_dram_seq #(
    .BANK_BITS (BANK_BITS),
    .ROW_W     (ROW_W),
    .REF_PERIOD(REF_PERIOD)
  ) u_seq (
    .clk_i    (C7M),
    .rst_i    (RES),
    .s_i      (s_q),
    .s_nxt_i  (s_d),
    .ramsel_i (ramsel_eff),
    .nwe_i    (nWE),
    .bank_i   (addr_q[ADDR_W-1 -: BANK_BITS]),
    .row_i    (row),
    .col_i    (addr_q[ROW_W-1:0]),
    .ra_o     (RA),
    .nras_o   (nRAS),
    .ncas_o   (nCAS),
    .nrwe_o   (nRWE)
  );

  assign Dout        = access ? rd_mux : 8'hFF;
  assign RD_o        = Din;
  assign DOE         = doe_q;
  assign RD_oe       = rd_oe_q;
  assign REGEN       = regen_q;
  assign dbg_state_o = s_q;

endmodule

// File: tb/tb_gr8ram_dram_ctl.sv
// Directed bench for gr8ram_dram_ctl: 7-clock bus cycles with per-state
// snapshots of the DRAM pins, checked against hand-computed values.
module tb_gr8ram_dram_ctl;
  import gr8ram_pkg::*;

  logic        C7M = 1'b0;
  logic        RES = 1'b1;
  logic        PHI1 = 1'b0;
  logic        nDEVSEL = 1'b1;
  logic        nIOSEL = 1'b1;
  logic [3:0]  A = 4'h0;
  logic        nWE = 1'b1;
  logic [7:0]  Din = 8'h00;
  logic [7:0]  RD_i = 8'hA5;
  logic [7:0]  Dout, RD_o;
  logic        DOE, RD_oe, nRAS, nRWE, REGEN;
  logic [10:0] RA;
  logic [1:0]  nCAS;
  state_e      dbg_state;

  gr8ram_dram_ctl #(
    .ADDR_W(23), .BANK_BITS(1), .ROW_W(11), .REF_PERIOD(13)
  ) dut (
    .C7M(C7M), .RES(RES), .PHI1(PHI1), .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL),
    .A(A), .nWE(nWE), .Din(Din), .Dout(Dout), .DOE(DOE), .RD_i(RD_i),
    .RD_o(RD_o), .RD_oe(RD_oe), .RA(RA), .nRAS(nRAS), .nCAS(nCAS),
    .nRWE(nRWE), .REGEN(REGEN), .dbg_state_o(dbg_state)
  );

  always #5 C7M = ~C7M;

  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_q[$];

  logic [2:0]  obs_state [8];
  logic [10:0] obs_ra    [8];
  logic        obs_nras  [8];
  logic [1:0]  obs_ncas  [8];
  logic        obs_nrwe  [8];
  logic        obs_doe   [8];
  logic        obs_rdoe  [8];
  logic        obs_regen [8];
  logic [7:0]  obs_dout  [8];
  logic [7:0]  obs_rdo   [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_edge(input logic phi1);
    PHI1 = phi1;
    @(posedge C7M);
    #1;
  endtask

  task automatic capture(input int i);
    obs_state[i] = dbg_state;
    obs_ra[i]    = RA;
    obs_nras[i]  = nRAS;
    obs_ncas[i]  = nCAS;
    obs_nrwe[i]  = nRWE;
    obs_doe[i]   = DOE;
    obs_rdoe[i]  = RD_oe;
    obs_regen[i] = REGEN;
    obs_dout[i]  = Dout;
    obs_rdo[i]   = RD_o;
  endtask

  // One full bus cycle: PHI1 high for 3 edges, low for 4; snapshot i = state Si.
  task automatic bus_cycle(input logic devsel_n, input logic iosel_n, input logic [3:0] a,
                           input logic we_n, input logic [7:0] d);
    nDEVSEL = devsel_n;
    nIOSEL  = iosel_n;
    A       = a;
    nWE     = we_n;
    Din     = d;
    for (int k = 0; k < 7; k++) begin
      drive_edge(k < 3);
      capture(k + 1);
    end
  endtask

  task automatic idle_cycle();
    bus_cycle(1'b1, 1'b1, 4'hF, 1'b1, 8'h00);
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
    bus_cycle(1'b0, 1'b1, a, 1'b0, d);
  endtask

  task automatic reg_read(input logic [3:0] a);
    bus_cycle(1'b0, 1'b1, a, 1'b1, 8'h00);
  endtask

  task automatic read_data_col(input string tag);
    logic [10:0] exp_col;
    reg_read(REG_DATA);
    exp_col = exp_q.pop_front();
    check_eq(tag, obs_ra[6], exp_col);
  endtask

  initial begin
    logic        strobe_seen;
    logic        ras_in_win;
    int          ref_count;
    int          first_ref;
    logic [7:0]  exp_rd0;

    // Reset, then idle with PHI1 low: nothing may move.
    for (int i = 0; i < 3; i++) drive_edge(1'b0);
    RES = 1'b0;
    strobe_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_edge(1'b0);
      strobe_seen |= ~nRAS | ~(&nCAS) | ~nRWE | (dbg_state != S_IDLE);
    end
    check_eq("idle_no_strobe", strobe_seen, 1'b0);
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_regen", REGEN, 1'b0);
    check_eq("rst_dout", Dout, 8'hFF);
    check_eq("rst_ra", RA, 11'h000);
    check_eq("rst_doe_rdoe", {DOE, RD_oe}, 2'b00);

    // C1: IOSEL enables the window; first bus cycle is a CBR refresh.
    bus_cycle(1'b1, 1'b0, 4'h0, 1'b1, 8'h00);
    check_eq("c1_state_s1", obs_state[1], S_1);
    check_eq("c1_state_s7", obs_state[7], S_7);
    check_eq("regen_s4", obs_regen[4], 1'b0);
    check_eq("regen_s5", obs_regen[5], 1'b1);
    check_eq("ref_s2", {obs_nras[2], obs_ncas[2]}, 3'b1_00);
    check_eq("ref_s3", {obs_nras[3], obs_ncas[3]}, 3'b0_00);
    check_eq("ref_s4", {obs_nras[4], obs_ncas[4]}, 3'b1_11);

    // C2..C4: Addr = $053412 -> bank 0, row $0A6, column $412.
    reg_write(REG_ADDRL, 8'h12);
    reg_write(REG_ADDRM, 8'h34);
    reg_write(REG_ADDRH, 8'h05);

    // C5: readback offset.
`ifdef GR8RAM_ADDR_READBACK_EN
    exp_rd0 = 8'h12;
`else
    exp_rd0 = 8'hFF;
`endif
    reg_read(REG_ADDRL);
    check_eq("rd_addrl", obs_dout[7], exp_rd0);
    check_eq("rd_addrl_nras", obs_nras[5], 1'b1);

    // C6..C8: data-port reads stepping up.
    exp_q.push_back(11'h412);
    exp_q.push_back(11'h413);
    exp_q.push_back(11'h414);
    read_data_col("rd0_col");
    check_eq("rd0_row", obs_ra[5], 11'h0A6);
    check_eq("rd0_nras_s5", obs_nras[5], 1'b0);
    check_eq("rd0_ncas_s5", obs_ncas[5], 2'b11);
    check_eq("rd0_ncas_s6", obs_ncas[6], 2'b10);
    check_eq("rd0_nrwe_s6", obs_nrwe[6], 1'b1);
    check_eq("rd0_doe_s4", obs_doe[4], 1'b0);
    check_eq("rd0_doe_s6", obs_doe[6], 1'b1);
    check_eq("rd0_rdoe_s6", obs_rdoe[6], 1'b0);
    check_eq("rd0_dout", obs_dout[7], 8'hA5);
    check_eq("rd0_ras_end", {obs_nras[1], obs_ncas[1]}, 3'b1_11);
    read_data_col("rd1_col");
    read_data_col("rd2_col");

    // C9: CTRL=11 (decrement); pending +1 still lands first -> $053415.
    reg_write(REG_CTRL, 8'h03);
    exp_q.push_back(11'h415);
    exp_q.push_back(11'h414);
    read_data_col("rd3_col");
    read_data_col("dec_col");

    // C12..C14: Addr = 0 (last write cycle is also the second refresh).
    reg_write(REG_ADDRL, 8'h00);
    reg_write(REG_ADDRM, 8'h00);
    reg_write(REG_ADDRH, 8'h00);
    check_eq("ref2_s2", obs_ncas[2], 2'b00);
    exp_q.push_back(11'h000);
    read_data_col("zero_col");
    check_eq("zero_row", obs_ra[5], 11'h000);
    check_eq("zero_ncas", obs_ncas[6], 2'b10);

    // C16: 0-1 wraps to $7FFFFF (bank 1); data-port write.
    bus_cycle(1'b0, 1'b1, REG_DATA, 1'b0, 8'h5A);
    check_eq("wr_row", obs_ra[5], 11'h7FF);
    check_eq("wr_col", obs_ra[6], 11'h7FF);
    check_eq("wr_nras_s5", obs_nras[5], 1'b0);
    check_eq("wr_ncas_s6", obs_ncas[6], 2'b11);
    check_eq("wr_ncas_s7", obs_ncas[7], 2'b01);
    check_eq("wr_nrwe_s6", obs_nrwe[6], 1'b1);
    check_eq("wr_nrwe_s7", obs_nrwe[7], 1'b0);
    check_eq("wr_rdoe_s4", obs_rdoe[4], 1'b0);
    check_eq("wr_rdoe_s5_s7", {obs_rdoe[5], obs_rdoe[6], obs_rdoe[7]}, 3'b111);
    check_eq("wr_doe_s6", obs_doe[6], 1'b0);
    check_eq("wr_rd_o", obs_rdo[7], 8'h5A);
    check_eq("wr_end", {obs_nras[1], obs_ncas[1], obs_nrwe[1], obs_rdoe[1]}, 5'b1_11_1_0);

    // C17..C42: idle; refreshes expected in C27 and C40.
    ref_count  = 0;
    first_ref  = -1;
    ras_in_win = 1'b0;
    for (int i = 0; i < 26; i++) begin
      idle_cycle();
      if (obs_ncas[2] == 2'b00) begin
        ref_count++;
        if (first_ref < 0) first_ref = i;
      end
      ras_in_win |= ~obs_nras[5] | ~obs_nras[6] | ~obs_nras[7] | (obs_ncas[6] != 2'b11);
    end
    check_eq("ref_count", ref_count, 2);
    check_eq("ref_first_idx", first_ref, 10);
    check_eq("idle_no_access", ras_in_win, 1'b0);

    // C43: read at $7FFFFE, RES during S6.
    nDEVSEL = 1'b0;
    nIOSEL  = 1'b1;
    A       = REG_DATA;
    nWE     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_edge(k < 3);
      capture(k + 1);
    end
    check_eq("abort_col", obs_ra[6], 11'h7FE);
    check_eq("abort_s6", {obs_nras[6], obs_ncas[6]}, 3'b0_01);
    RES = 1'b1;
    drive_edge(1'b0);
    check_eq("abort_strobes", {nRAS, nCAS, nRWE}, 4'b1_11_1);
    check_eq("abort_state", dbg_state, S_IDLE);
    check_eq("abort_regen", REGEN, 1'b0);
    RES = 1'b0;
    nDEVSEL = 1'b1;
    for (int i = 0; i < 2; i++) drive_edge(1'b0);

    // Re-enable and read: Addr must be 0 with no leftover increment.
    bus_cycle(1'b1, 1'b0, 4'h0, 1'b1, 8'h00);
    exp_q.push_back(11'h000);
    read_data_col("post_rst_col");
    check_eq("post_rst_row", obs_ra[5], 11'h000);
    check_eq("post_rst_ncas", obs_ncas[6], 2'b10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
